// File: rtl/bin_to_bcd_if.sv
// Request/result bundle for the binary-to-BCD converter.
// The master drives Start/BinIn; the slave returns the BCD result and status.
interface bin_to_bcd_if #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
);
  logic                  Start;
  logic [BIN_W-1:0]      BinIn;
  logic [4*DIGITS-1:0]   BCDOut;
  logic                  Busy;
  logic                  Done;
  logic                  Overflow;

  modport master (
    output Start,
    output BinIn,
    input  BCDOut,
    input  Busy,
    input  Done,
    input  Overflow
  );

  modport slave (
    input  Start,
    input  BinIn,
    output BCDOut,
    output Busy,
    output Done,
    output Overflow
  );
endinterface

// File: rtl/bin_to_bcd.sv
// Sequential shift-add-3 binary-to-BCD converter: one bit per cycle, BIN_W cycles per result.
// Results saturate to all nines when the input does not fit in DIGITS decimal digits.
module bin_to_bcd #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic           Clk,
  input  logic           Rst,
  bin_to_bcd_if.slave    bus
);

  // (BIN_W+2)/3 digits always cover 2^BIN_W-1, so no carry is ever lost.
  localparam int unsigned AccD   = ((BIN_W + 2) / 3 > DIGITS) ? (BIN_W + 2) / 3 : DIGITS;
  localparam int unsigned AccW   = 4 * AccD;
  localparam int unsigned CntW   = $clog2(BIN_W);
  localparam int unsigned MaxVal = 10 ** DIGITS - 1;
  localparam logic [4*DIGITS-1:0] Nines = {DIGITS{4'h9}};

  typedef enum logic {StIdle, StConv} state_e;

  state_e                r_state, w_state_next;
  logic [BIN_W-1:0]      r_sh, w_sh_next, w_sh_sh;
  logic [AccW-1:0]       r_acc, w_acc_next, w_acc_sh, w_adj;
  logic [CntW-1:0]       r_cnt, w_cnt_next;
  logic                  r_ovf_pend, w_ovf_pend_next;
  logic [4*DIGITS-1:0]   r_bcd, w_bcd_next;
  logic                  r_ovf, w_ovf_next;
  logic                  r_done, w_done_next;

  always_comb begin
    w_adj = r_acc;
    for (int unsigned i = 0; i < AccD; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
    end
  end

  assign {w_acc_sh, w_sh_sh} = {w_adj, r_sh} << 1;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state    <= StIdle;
      r_sh       <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_sh       <= w_sh_next;
      r_acc      <= w_acc_next;
      r_cnt      <= w_cnt_next;
      r_ovf_pend <= w_ovf_pend_next;
      r_bcd      <= w_bcd_next;
      r_ovf      <= w_ovf_next;
      r_done     <= w_done_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_sh_next       = r_sh;
    w_acc_next      = r_acc;
    w_cnt_next      = r_cnt;
    w_ovf_pend_next = r_ovf_pend;
    w_bcd_next      = r_bcd;
    w_ovf_next      = r_ovf;
    w_done_next     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.Start) begin
          w_state_next    = StConv;
          w_sh_next       = bus.BinIn;
          w_acc_next      = '0;
          w_cnt_next      = CntW'(BIN_W - 1);
          w_ovf_pend_next = (32'(bus.BinIn) > MaxVal);
        end
      end
      StConv: begin
        w_sh_next  = w_sh_sh;
        w_acc_next = w_acc_sh;
        w_cnt_next = r_cnt - CntW'(1);
        if (r_cnt == '0) begin
          w_state_next = StIdle;
          w_cnt_next   = '0;
          w_done_next  = 1'b1;
          w_ovf_next   = r_ovf_pend;
          w_bcd_next   = r_ovf_pend ? Nines : w_acc_sh[4*DIGITS-1:0];
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign bus.BCDOut   = r_bcd;
  assign bus.Busy     = (r_state == StConv);
  assign bus.Done     = r_done;
  assign bus.Overflow = r_ovf;

endmodule

// File: doc/bin_to_bcd.md
BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 Parameter BIN_W, default 14: binary input width in bits, legal range 4..20.
REQ-002 Parameter DIGITS, default 4: number of BCD output digits, legal range 1..6.
REQ-003 Port Clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 Port Rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port Start, input, 1 bit: conversion request, sampled on the Clk rising edge.
REQ-006 Port BinIn, input, BIN_W bits: unsigned binary value, sampled on the edge that accepts Start.
REQ-007 Port BCDOut, output, 4*DIGITS bits: packed BCD result, least significant digit in bits [3:0]; each digit drives one downstream 4-bit BCD-to-seven-segment decoder.
REQ-008 Port Busy, output, 1 bit: high while a conversion is in progress.
REQ-009 Port Done, output, 1 bit: one-cycle pulse marking the edge on which BCDOut and Overflow were updated.
REQ-010 Port Overflow, output, 1 bit: set when the last accepted BinIn exceeded 10^DIGITS-1.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and CONV.
REQ-012 In IDLE, Start=1 on an edge SHALL latch BinIn into the shift register, clear the BCD accumulator, load the iteration counter with BIN_W-1 and move the FSM to CONV.
REQ-013 In IDLE, Start=0 SHALL leave all state unchanged.
REQ-014 Each CONV cycle SHALL first add 3 to every accumulator digit that is >=5, then shift the {accumulator, shift register} pair left by one bit (shift-add-3).
REQ-015 The CONV state SHALL last exactly BIN_W cycles.
REQ-016 On the final CONV cycle (counter=0), the FSM SHALL return to IDLE, register the corrected result into BCDOut and set Done for exactly one cycle.
REQ-017 Latency: Start accepted at edge k gives BCDOut valid and Done=1 from edge k+BIN_W.
REQ-018 Busy SHALL be decoded from the state register (Busy=1 iff state=CONV), with no combinational path from Start.
REQ-019 Start SHALL be ignored while in CONV; the conversion in progress and its BinIn are unaffected.
REQ-020 Start=1 during the cycle in which Done=1 SHALL be accepted, giving back-to-back conversions every BIN_W+1 cycles.
REQ-021 Overflow SHALL be computed from the latched BinIn at acceptance, compared against the constant 10^DIGITS-1, and registered with BCDOut on the Done edge.
REQ-022 On overflow, BCDOut SHALL saturate to all digits equal to 9.
REQ-023 BCDOut and Overflow SHALL hold their values between Done pulses and SHALL NOT show intermediate accumulator values.
REQ-024 The accumulator SHALL be wide enough for BIN_W iterations without loss; digits above DIGITS SHALL be used only for the overflow decision.
REQ-025 Every digit of BCDOut SHALL always be in the range 0..9.

Reset
REQ-026 Asserting Rst SHALL immediately, without a clock edge, force: state=IDLE, Busy=0, Done=0, Overflow=0, BCDOut=0, counter=0, accumulator=0.
REQ-027 Rst asserted during CONV SHALL abort the conversion; no Done pulse SHALL follow.
REQ-028 BCDOut SHALL remain 0 until a new conversion completes.
REQ-029 Start SHALL be ignored while Rst=1.
REQ-030 After Rst deasserts, the first rising edge SHALL be able to accept Start.

Verification
REQ-031 Defaults: BinIn=0, Start pulse -> Done at k+14, BCDOut=0x0000, Overflow=0.
REQ-032 BinIn=1234, Start pulse -> Busy high for 14 cycles, Done at k+14, BCDOut=0x1234; BinIn=9999 -> BCDOut=0x9999, Overflow=0.
REQ-033 BinIn=10000 -> BCDOut=0x9999, Overflow=1; BinIn=16383 -> BCDOut=0x9999, Overflow=1; then BinIn=42 -> BCDOut=0x0042, Overflow=0.
REQ-034 Start=1 on BinIn=5678, then Start=1 with BinIn=1111 at k+3 -> a single Done at k+14 with BCDOut=0x5678.
REQ-035 Start held high continuously with BinIn=0321 -> Done every 15 cycles, BCDOut=0x0321 each time.
REQ-036 Rst pulsed at k+7 of a conversion of 4321 -> outputs 0 asynchronously, no Done; a new Start converts 4321 normally.
